// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and width helpers for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_ASSERT  = 2'd0,
        SEQ_RELEASE = 2'd1,
        SEQ_DONE    = 2'd2
    } seq_state_e;

    // Wide enough to reach the larger of the hold and stagger terminal counts.
    function automatic int timer_width(input int hold_cycles, input int stagger_cycles);
        int m;
        m = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
        return $clog2(m + 1);
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/reset_seq_if.sv
// rtl/reset_seq_if.sv - control/status bundle of the reset sequencer (RESET_SEQ_SOFT_RST_EN adds soft_rst_req)
interface reset_seq_if #(
    parameter int NUM_CH = 4
);
    logic              hold_req;
`ifdef RESET_SEQ_SOFT_RST_EN
    logic [NUM_CH-1:0] soft_rst_req;
`endif
    logic [NUM_CH-1:0] target_rst_vec;
    logic [NUM_CH-1:0] target_rst_n_vec;
    logic              seq_done;

    modport master (
`ifdef RESET_SEQ_SOFT_RST_EN
        input  soft_rst_req,
`endif
        input  hold_req,
        output target_rst_vec,
        output target_rst_n_vec,
        output seq_done
    );

    modport slave (
`ifdef RESET_SEQ_SOFT_RST_EN
        output soft_rst_req,
`endif
        output hold_req,
        input  target_rst_vec,
        input  target_rst_n_vec,
        input  seq_done
    );
endinterface

// File: rtl/reset_seq_timer.sv
// rtl/reset_seq_timer.sv - clearable up-counter with terminal-count compare
module reset_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == tc_val);
endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered multi-channel reset release with hold and stagger
// Optional per-channel soft reset in DONE when RESET_SEQ_SOFT_RST_EN is defined.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic         target_clk,
    input  logic         target_rst,
    reset_seq_if.master  bus
);
    localparam int TW = timer_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int CW = ch_width(NUM_CH);

    localparam logic [1:0] ST_ASSERT  = SEQ_ASSERT;
    localparam logic [1:0] ST_RELEASE = SEQ_RELEASE;
    localparam logic [1:0] ST_DONE    = SEQ_DONE;

    localparam logic [TW-1:0] HOLD_TC  = TW'(HOLD_CYCLES);
    // Timer restarts from zero on each release edge, so stagger terminal is one short.
    localparam logic [TW-1:0] STAG_TC  = TW'(STAGGER_CYCLES - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

    logic [1:0]        state, state_nxt;
    logic [CW-1:0]     idx, idx_nxt;
    logic [NUM_CH-1:0] vec, vec_n, vec_nxt;
    logic              done, done_nxt;
    logic              tmr_clr, tmr_en, tmr_tc;
    logic [TW-1:0]     tmr_tc_val;
    logic              soft_hit;
    logic [CW-1:0]     soft_ch;

    function automatic logic [NUM_CH-1:0] mask_from(input int k);
        logic [NUM_CH-1:0] m;
        for (int i = 0; i < NUM_CH; i++) begin
            m[i] = (i >= k);
        end
        return m;
    endfunction

`ifdef RESET_SEQ_SOFT_RST_EN
    always_comb begin
        soft_hit = 1'b0;
        soft_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.soft_rst_req[i]) begin
                soft_hit = 1'b1;
                soft_ch  = CW'(i);
            end
        end
    end
`else
    assign soft_hit = 1'b0;
    assign soft_ch  = '0;
`endif

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        vec_nxt    = vec;
        done_nxt   = done;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        tmr_tc_val = (state == ST_RELEASE) ? STAG_TC : HOLD_TC;
        if (target_rst || bus.hold_req) begin
            state_nxt = ST_ASSERT;
            idx_nxt   = '0;
            vec_nxt   = '1;
            done_nxt  = 1'b0;
            tmr_clr   = 1'b1;
        end else begin
            case (state)
                ST_ASSERT, ST_RELEASE: begin
                    if (tmr_tc) begin
                        vec_nxt = mask_from(int'(idx) + 1);
                        tmr_clr = 1'b1;
                        if (idx == LAST_CH) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_RELEASE;
                            idx_nxt   = idx + CW'(1);
                        end
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_DONE: begin
                    // The trigger edge itself counts as the first hold cycle.
                    if (soft_hit) begin
                        state_nxt = ST_ASSERT;
                        idx_nxt   = soft_ch;
                        vec_nxt   = mask_from(int'(soft_ch));
                        done_nxt  = 1'b0;
                        tmr_en    = 1'b1;
                    end else begin
                        tmr_clr = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_ASSERT;
                    idx_nxt   = '0;
                    vec_nxt   = '1;
                    done_nxt  = 1'b0;
                    tmr_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge target_clk) begin
        if (target_rst) begin
            state <= ST_ASSERT;
            idx   <= '0;
            vec   <= '1;
            vec_n <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            vec   <= vec_nxt;
            vec_n <= ~vec_nxt;
            done  <= done_nxt;
        end
    end

    reset_seq_timer #(.W(TW)) u_timer (
        .clk    (target_clk),
        .rst    (target_rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .tc_val (tmr_tc_val),
        .tc     (tmr_tc)
    );

    assign bus.target_rst_vec   = vec;
    assign bus.target_rst_n_vec = vec_n;
    assign bus.seq_done         = done;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer (4-ch 16/8 and 1-ch hold 1)
module tb_reset_sequencer;
    logic target_clk = 1'b0;
    logic target_rst = 1'b1;
    logic rst1       = 1'b1;
    int   pass_cnt   = 0;
    int   total_cnt  = 0;

    always #5 target_clk = ~target_clk;

    reset_seq_if #(.NUM_CH(4)) bus  ();
    reset_seq_if #(.NUM_CH(1)) bus1 ();

    reset_sequencer #(.NUM_CH(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(8)) dut (
        .target_clk (target_clk),
        .target_rst (target_rst),
        .bus        (bus.master)
    );

    reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(8)) dut1 (
        .target_clk (target_clk),
        .target_rst (rst1),
        .bus        (bus1.master)
    );

    task automatic tick();
        @(posedge target_clk);
        #1;
    endtask

    // Expected vector after relative edge e of a full sequence.
    function automatic logic [3:0] exp_vec(input int e);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (e < 16 + 8 * i);
        return v;
    endfunction

    // Runs relative edges first..last of a full sequence, checking each edge.
    task automatic run_seq(input string name, input int first, input int last);
        for (int e = first; e <= last; e++) begin
            tick();
            total_cnt++;
            if (bus.target_rst_vec !== exp_vec(e) || bus.target_rst_n_vec !== ~exp_vec(e)
                || bus.seq_done !== (e >= 40))
                $display("FAIL %s edge %0d: vec=%h n=%h done=%b required vec=%h n=%h done=%b",
                         name, e, bus.target_rst_vec, bus.target_rst_n_vec, bus.seq_done,
                         exp_vec(e), ~exp_vec(e), (e >= 40));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        target_rst   = 1'b1;
        bus.hold_req = 1'b0;
`ifdef RESET_SEQ_SOFT_RST_EN
        bus.soft_rst_req = '0;
`endif
        repeat (5) tick();
        total_cnt++;
        if (bus.target_rst_vec !== 4'hF || bus.target_rst_n_vec !== 4'h0 || bus.seq_done !== 1'b0)
            $display("FAIL reset_state: vec=%h n=%h done=%b required vec=f n=0 done=0",
                     bus.target_rst_vec, bus.target_rst_n_vec, bus.seq_done);
        else pass_cnt++;
        target_rst = 1'b0;
        run_seq("power_on", 0, 40);
    endtask

    task automatic test_hold();
        target_rst = 1'b1;
        tick();
        target_rst   = 1'b0;
        bus.hold_req = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            total_cnt++;
            if (bus.target_rst_vec !== 4'hF || bus.seq_done !== 1'b0)
                $display("FAIL hold edge %0d: vec=%h done=%b required vec=f done=0",
                         e, bus.target_rst_vec, bus.seq_done);
            else pass_cnt++;
        end
        bus.hold_req = 1'b0;
        run_seq("hold_release", 0, 40);
    endtask

    task automatic test_mid_reset();
        target_rst = 1'b1;
        tick();
        target_rst = 1'b0;
        run_seq("pre_pulse", 0, 27);
        target_rst = 1'b1;
        tick();
        target_rst = 1'b0;
        total_cnt++;
        if (bus.target_rst_vec !== 4'hF || bus.seq_done !== 1'b0)
            $display("FAIL mid_reset: vec=%h done=%b required vec=f done=0",
                     bus.target_rst_vec, bus.seq_done);
        else pass_cnt++;
        run_seq("post_pulse", 0, 40);
    endtask

    task automatic test_hold_in_done();
        bus.hold_req = 1'b1;
        tick();
        bus.hold_req = 1'b0;
        total_cnt++;
        if (bus.target_rst_vec !== 4'hF || bus.target_rst_n_vec !== 4'h0 || bus.seq_done !== 1'b0)
            $display("FAIL hold_in_done: vec=%h n=%h done=%b required vec=f n=0 done=0",
                     bus.target_rst_vec, bus.target_rst_n_vec, bus.seq_done);
        else pass_cnt++;
        run_seq("replay", 0, 40);
    endtask

`ifdef RESET_SEQ_SOFT_RST_EN
    task automatic test_soft_rst();
        logic [3:0] ev;
        bus.soft_rst_req = 4'b0110;
        tick();
        bus.soft_rst_req = 4'b0000;
        total_cnt++;
        if (bus.target_rst_vec !== 4'b1110 || bus.seq_done !== 1'b0)
            $display("FAIL soft_assert: vec=%h done=%b required vec=e done=0",
                     bus.target_rst_vec, bus.seq_done);
        else pass_cnt++;
        for (int k = 1; k <= 32; k++) begin
            tick();
            ev = {(k < 32), (k < 24), (k < 16), 1'b0};
            total_cnt++;
            if (bus.target_rst_vec !== ev || bus.target_rst_n_vec !== ~ev || bus.seq_done !== (k >= 32))
                $display("FAIL soft_seq +%0d: vec=%h n=%h done=%b required vec=%h done=%b",
                         k, bus.target_rst_vec, bus.target_rst_n_vec, bus.seq_done, ev, (k >= 32));
            else pass_cnt++;
        end
        target_rst = 1'b1;
        tick();
        target_rst = 1'b0;
        run_seq("soft_ignored_a", 0, 19);
        bus.soft_rst_req = 4'b0001;
        run_seq("soft_ignored_b", 20, 20);
        bus.soft_rst_req = 4'b0000;
        run_seq("soft_ignored_c", 21, 40);
    endtask
`endif

    task automatic test_single_channel();
        bus1.hold_req = 1'b0;
`ifdef RESET_SEQ_SOFT_RST_EN
        bus1.soft_rst_req = '0;
`endif
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        tick();
        total_cnt++;
        if (bus1.target_rst_vec !== 1'b1 || bus1.target_rst_n_vec !== 1'b0 || bus1.seq_done !== 1'b0)
            $display("FAIL single_edge0: vec=%b n=%b done=%b required vec=1 n=0 done=0",
                     bus1.target_rst_vec, bus1.target_rst_n_vec, bus1.seq_done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus1.target_rst_vec !== 1'b0 || bus1.target_rst_n_vec !== 1'b1 || bus1.seq_done !== 1'b1)
            $display("FAIL single_edge1: vec=%b n=%b done=%b required vec=0 n=1 done=1",
                     bus1.target_rst_vec, bus1.target_rst_n_vec, bus1.seq_done);
        else pass_cnt++;
    endtask

    initial begin
        bus1.hold_req = 1'b0;
        test_reset();
        test_hold();
        test_mid_reset();
        test_hold_in_done();
`ifdef RESET_SEQ_SOFT_RST_EN
        test_soft_rst();
`endif
        test_single_channel();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
